// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential multiplier.
package mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN_ADD, RUN_SHIFT, DONE} mult_state_t;
    localparam logic MODE_ADD   = 1'b0;
    localparam logic MODE_SHIFT = 1'b1;
endpackage

// File: rtl/mult_seq_if.sv
// Host-side handshake bundle: start/ready request channel, valid/ack result channel.
interface mult_seq_if #(parameter int WIDTH = 4);
    logic                 start_i;
    logic                 mode_i;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic                 ready_o;
    logic                 valid_o;
    logic [2*WIDTH-1:0]   product_o;
    logic                 ack_i;

    modport master (output start_i, mode_i, a_i, b_i, ack_i,
                    input  ready_o, valid_o, product_o);
    modport slave  (input  start_i, mode_i, a_i, b_i, ack_i,
                    output ready_o, valid_o, product_o);
endinterface

// File: rtl/mult_seq_dp.sv
// Multiplier datapath: multiplicand P, multiplier/count Q, accumulator F, shift iteration counter.
module mult_seq_dp #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 add_en,
    input  logic                 dec_q,
    input  logic                 shift_en,
    input  logic                 clr_f,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 q_zero,
    output logic                 q_lsb,
    output logic                 iter_last,
    output logic [2*WIDTH-1:0]   f
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_END = CW'(WIDTH);

    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] sum;

    // Final product fits in 2*WIDTH bits, so the carry out is dropped.
    assign sum       = f + p;
    assign q_zero    = (q == '0);
    assign q_lsb     = q[0];
    assign iter_last = (cnt == CNT_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p   <= '0;
            q   <= '0;
            f   <= '0;
            cnt <= '0;
        end else begin
            if (load) begin
                p   <= {{WIDTH{1'b0}}, a};
                q   <= b;
                cnt <= '0;
            end else begin
                if (dec_q)
                    q <= q - 1'b1;
                if (shift_en) begin
                    p   <= p << 1;
                    q   <= q >> 1;
                    cnt <= cnt + 1'b1;
                end
            end
            if (clr_f)
                f <= '0;
            else if (add_en)
                f <= sum;
        end
    end
endmodule

// File: rtl/mult_seq.sv
// Sequential unsigned multiplier: controller FSM around mult_seq_dp, two selectable algorithms.
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    mult_seq_if.slave  bus
);
    mult_state_t        state, state_nxt;
    logic               load, add_en, dec_q, shift_en, clr_f, capture;
    logic               q_zero, q_lsb, iter_last;
    logic [2*WIDTH-1:0] f;
    logic [2*WIDTH-1:0] product_q;

    mult_seq_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk_i),
        .rst       (rst_i),
        .load      (load),
        .add_en    (add_en),
        .dec_q     (dec_q),
        .shift_en  (shift_en),
        .clr_f     (clr_f),
        .a         (bus.a_i),
        .b         (bus.b_i),
        .q_zero    (q_zero),
        .q_lsb     (q_lsb),
        .iter_last (iter_last),
        .f         (f)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            product_q <= '0;
        end else begin
            state <= state_nxt;
            if (capture)
                product_q <= f;
        end
    end

    // The chosen RUN_* state carries the mode, so it needs no register of its own.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        clr_f     = 1'b0;
        add_en    = 1'b0;
        dec_q     = 1'b0;
        shift_en  = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE: if (bus.start_i) begin
                load      = 1'b1;
                clr_f     = 1'b1;
                state_nxt = (bus.mode_i == MODE_SHIFT) ? RUN_SHIFT : RUN_ADD;
            end
            RUN_ADD: if (q_zero) begin
                capture   = 1'b1;
                state_nxt = DONE;
            end else begin
                add_en = 1'b1;
                dec_q  = 1'b1;
            end
            RUN_SHIFT: if (iter_last) begin
                capture   = 1'b1;
                state_nxt = DONE;
            end else begin
                add_en   = q_lsb;
                shift_en = 1'b1;
            end
            DONE: if (bus.ack_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ready_o   = (state == IDLE);
    assign bus.valid_o   = (state == DONE);
    assign bus.product_o = product_q;
endmodule

// File: tb/tb_mult_seq.sv
// Directed and random checks of mult_seq at WIDTH=4 and WIDTH=8 with a product scoreboard.
module tb_mult_seq;
    import mult_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    bit          sel8 = 1'b0;
    logic        start = 1'b0, mode = 1'b0, ack = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic        rdy, vld;
    logic [63:0] prod;
    int          n_chk = 0, n_pass = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    mult_seq_if #(.WIDTH(4)) bus4();
    mult_seq_if #(.WIDTH(8)) bus8();

    mult_seq #(.WIDTH(4)) u4 (.clk_i(clk), .rst_i(rst), .bus(bus4));
    mult_seq #(.WIDTH(8)) u8 (.clk_i(clk), .rst_i(rst), .bus(bus8));

    assign bus4.start_i = start & ~sel8;
    assign bus8.start_i = start & sel8;
    assign bus4.ack_i   = ack & ~sel8;
    assign bus8.ack_i   = ack & sel8;
    assign bus4.mode_i  = mode;
    assign bus8.mode_i  = mode;
    assign bus4.a_i     = a[3:0];
    assign bus4.b_i     = b[3:0];
    assign bus8.a_i     = a;
    assign bus8.b_i     = b;
    assign rdy  = sel8 ? bus8.ready_o : bus4.ready_o;
    assign vld  = sel8 ? bus8.valid_o : bus4.valid_o;
    assign prod = sel8 ? {48'd0, bus8.product_o} : {56'd0, bus4.product_o};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One transaction on the selected unit; hold keeps start high and scrambles operands while busy.
    task automatic run_op(input bit m, input int ai, input int bi, input int ackdly, input bit hold);
        int          k, lat, exp_lat;
        logic [63:0] exp_p;
        k = 0;
        while (!rdy && k < 300) begin @(negedge clk); k++; end
        chk("ready_before_start", rdy, 1);
        start = 1'b1; mode = m; a = 8'(ai); b = 8'(bi);
        sb.push_back(64'(ai) * 64'(bi));
        exp_lat = m ? (sel8 ? 9 : 5) : bi + 1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk("ready_drops", rdy, 0);
        lat = 0;
        while (!vld && lat < 300) begin
            if (hold) begin a = 8'($urandom); b = 8'($urandom); mode = ~mode; end
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("ready_low_in_done", rdy, 0);
        exp_p = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
        chk("product", prod, exp_p);
        repeat (ackdly) begin
            if (hold) begin a = 8'($urandom); b = 8'($urandom); end
            @(negedge clk);
        end
        chk("valid_held", vld, 1);
        chk("product_held", prod, exp_p);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("valid_after_ack", vld, 0);
        chk("ready_after_ack", rdy, 1);
        chk("product_kept", prod, exp_p);
        start = 1'b0;
    endtask

    initial begin
        int m, ai, bi;
        #1;
        chk("rst_ready", bus4.ready_o, 1);
        chk("rst_valid", bus4.valid_o, 0);
        chk("rst_product", {56'd0, bus4.product_o}, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(0, 7, 3, 10, 0);
        run_op(1, 15, 15, 0, 0);
        run_op(0, 15, 15, 1, 0);
        run_op(0, 9, 0, 0, 0);
        run_op(1, 0, 11, 3, 0);
        run_op(0, 5, 6, 2, 1);

        // Asynchronous reset in the middle of a repeated-addition run.
        start = 1'b1; mode = 1'b0; a = 8'd3; b = 8'd12;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", {62'd0, u4.state}, {62'd0, IDLE});
        chk("arst_ready", bus4.ready_o, 1);
        chk("arst_valid", bus4.valid_o, 0);
        chk("arst_product", {56'd0, bus4.product_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        run_op(0, 2, 2, 0, 0);

        sel8 = 1'b1;
        @(negedge clk);
        run_op(0, 255, 255, 0, 0);
        run_op(1, 255, 255, 1, 0);
        for (int i = 0; i < 1000; i++) begin
            m  = $urandom_range(0, 1);
            ai = $urandom_range(0, 255);
            if (m == 1 || $urandom_range(0, 7) == 0) bi = $urandom_range(0, 255);
            else bi = $urandom_range(0, 31);
            run_op(m[0], ai, bi, $urandom_range(0, 5), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
